// File: rtl/mem_stage.sv
// MEM pipeline stage: accepts the EX bundle, waits for the data-SRAM response on loads,
// aligns/extends load data and drives the MEM->WB bus and the ID forwarding bus.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_to_MEM_valid,
  output logic        MEM_allowin,
  input  logic [75:0] EX_to_MEM_BUS,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        MEM_to_WB_valid,
  input  logic        WB_allowin,
  output logic [70:0] MEM_to_WB_BUS,
  output logic [37:0] MEM_RF_BUS
);

  localparam int unsigned EX_TO_MEM_LEN = 76;
  localparam int unsigned MEM_TO_WB_LEN = 71;
  localparam int unsigned MEM_RF_LEN    = 38;

  // load_op is one-hot: [0] ld.b, [1] ld.bu, [2] ld.h, [3] ld.hu, [4] ld.w
  typedef enum logic [1:0] {IDLE, WAIT, HAVE} state_e;

  state_e                     state_q, state_d;
  logic [EX_TO_MEM_LEN-1:0]   ex_bus_q, ex_bus_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;

  logic [31:0] pc;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [4:0]  load_op;
  logic        res_from_mem;

  logic        mem_valid;
  logic        resp_now;
  logic        ready_go;
  logic        transfer;
  logic [31:0] word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;
  logic [31:0] final_result;

  assign {pc, gr_we, dest, alu_result, load_op, res_from_mem} = ex_bus_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ex_bus_q    <= '0;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_bus_q    <= ex_bus_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // data_ok only belongs to the resident instruction while it is waiting for it
  assign mem_valid = (state_q != IDLE);
  assign resp_now  = (state_q == WAIT) && data_sram_data_ok;
  assign ready_go  = (state_q == HAVE) || resp_now;
  assign transfer  = EX_to_MEM_valid && MEM_allowin;

  always_comb begin
    state_d     = state_q;
    ex_bus_d    = ex_bus_q;
    rdata_buf_d = rdata_buf_q;
    if (resp_now) begin
      rdata_buf_d = data_sram_rdata;
    end
    if (MEM_allowin) begin
      if (transfer) begin
        ex_bus_d = EX_to_MEM_BUS;
        state_d  = EX_to_MEM_BUS[0] ? WAIT : HAVE;
      end else begin
        state_d = IDLE;
      end
    end else if (resp_now) begin
      state_d = HAVE;
    end
  end

  always_comb begin
    MEM_allowin     = !mem_valid || (ready_go && WB_allowin);
    MEM_to_WB_valid = mem_valid && ready_go;

    word = resp_now ? data_sram_rdata : rdata_buf_q;
    case (alu_result[1:0])
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = alu_result[1] ? word[31:16] : word[15:0];

    if (load_op[0])      load_result = {{24{sel_byte[7]}}, sel_byte};
    else if (load_op[1]) load_result = {24'd0, sel_byte};
    else if (load_op[2]) load_result = {{16{sel_half[15]}}, sel_half};
    else if (load_op[3]) load_result = {16'd0, sel_half};
    else                 load_result = word;

    final_result  = res_from_mem ? load_result : alu_result;
    MEM_to_WB_BUS = {pc, gr_we, dest, final_result, res_from_mem};
    MEM_RF_BUS    = {dest & {5{gr_we && mem_valid}},
                     mem_valid && res_from_mem && !ready_go,
                     final_result};
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshakes, load alignment, back-pressure and reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_to_MEM_valid;
  logic        MEM_allowin;
  logic [75:0] EX_to_MEM_BUS;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        MEM_to_WB_valid;
  logic        WB_allowin;
  logic [70:0] MEM_to_WB_BUS;
  logic [37:0] MEM_RF_BUS;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_to_MEM_valid   (EX_to_MEM_valid),
    .MEM_allowin       (MEM_allowin),
    .EX_to_MEM_BUS     (EX_to_MEM_BUS),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .MEM_to_WB_valid   (MEM_to_WB_valid),
    .WB_allowin        (WB_allowin),
    .MEM_to_WB_BUS     (MEM_to_WB_BUS),
    .MEM_RF_BUS        (MEM_RF_BUS)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dst, input logic [31:0] alu,
                                        input logic [4:0] lop, input logic rfm);
    return {pc, we, dst, alu, lop, rfm};
  endfunction

  function automatic logic [70:0] mk_wb(input logic [31:0] pc, input logic we,
                                        input logic [4:0] dst, input logic [31:0] res,
                                        input logic rfm);
    return {pc, we, dst, res, rfm};
  endfunction

  task automatic check(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    EX_to_MEM_valid   = 1'b0;
    EX_to_MEM_BUS     = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    WB_allowin        = 1'b1;
    tick();
    data_sram_data_ok = 1'b1;  // ignored during reset
    data_sram_rdata   = 32'hFFFF_FFFF;
    tick();
    reset             = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    check("rst_valid",   MEM_to_WB_valid, 0);
    check("rst_allowin", MEM_allowin, 1);
    check("rst_wbbus",   MEM_to_WB_BUS, 0);
    check("rst_rfbus",   MEM_RF_BUS, 0);

    // Non-load back-to-back
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_BUS   = mk_ex(32'h1000, 1'b1, 5'd5, 32'h1234_5678, 5'd0, 1'b0);
    tick();
    EX_to_MEM_BUS   = mk_ex(32'h1004, 1'b1, 5'd6, 32'h0000_000A, 5'd0, 1'b0);
    #1;
    check("add_valid",   MEM_to_WB_valid, 1);
    check("add_bus",     MEM_to_WB_BUS, mk_wb(32'h1000, 1'b1, 5'd5, 32'h1234_5678, 1'b0));
    check("add_rf",      MEM_RF_BUS, {5'd5, 1'b0, 32'h1234_5678});
    check("add_allowin", MEM_allowin, 1);
    tick();
    EX_to_MEM_valid = 1'b0;
    #1;
    check("add2_bus",    MEM_to_WB_BUS, mk_wb(32'h1004, 1'b1, 5'd6, 32'h0000_000A, 1'b0));
    tick();
    check("add_drain",   MEM_to_WB_valid, 0);
    check("idle_rfdst",  MEM_RF_BUS[37:32], 6'd0);

    // ld.b at offset 2, response 3 cycles late
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_BUS   = mk_ex(32'h2000, 1'b1, 5'd7, 32'h0000_0102, 5'b00001, 1'b1);
    tick();
    EX_to_MEM_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ldb_wait_allowin", MEM_allowin, 0);
      check("ldb_wait_valid",   MEM_to_WB_valid, 0);
      check("ldb_wait_rf",      MEM_RF_BUS[37:32], {5'd7, 1'b1});
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0080_FF00;
    #1;
    check("ldb_valid", MEM_to_WB_valid, 1);
    check("ldb_bus",   MEM_to_WB_BUS, mk_wb(32'h2000, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1));
    check("ldb_rfpend", MEM_RF_BUS[32], 0);
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("ldb_done", MEM_to_WB_valid, 0);

    // ld.hu at offset 2, response in the accept+1 cycle together with a new transfer-in
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_BUS   = mk_ex(32'h3000, 1'b1, 5'd8, 32'h0000_0202, 5'b01000, 1'b1);
    tick();
    EX_to_MEM_BUS     = mk_ex(32'h3004, 1'b1, 5'd9, 32'h0000_0077, 5'd0, 1'b0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    #1;
    check("ldhu_valid",   MEM_to_WB_valid, 1);
    check("ldhu_bus",     MEM_to_WB_BUS, mk_wb(32'h3000, 1'b1, 5'd8, 32'h0000_8001, 1'b1));
    check("ldhu_allowin", MEM_allowin, 1);
    tick();
    EX_to_MEM_valid   = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    check("after_ldhu_bus", MEM_to_WB_BUS, mk_wb(32'h3004, 1'b1, 5'd9, 32'h0000_0077, 1'b0));
    tick();
    check("after_ldhu_done", MEM_to_WB_valid, 0);

    // ld.w under WB back-pressure for 4 cycles
    WB_allowin      = 1'b0;
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_BUS   = mk_ex(32'h4000, 1'b1, 5'd10, 32'h0000_0300, 5'b10000, 1'b1);
    tick();
    EX_to_MEM_valid   = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    check("bp_valid0",   MEM_to_WB_valid, 1);
    check("bp_res0",     MEM_to_WB_BUS[32:1], 32'hDEAD_BEEF);
    check("bp_allowin0", MEM_allowin, 0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h1212_3434;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_valid", MEM_to_WB_valid, 1);
      check("bp_hold_bus",   MEM_to_WB_BUS, mk_wb(32'h4000, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1));
      tick();
    end
    WB_allowin = 1'b1;
    #1;
    check("bp_release_allowin", MEM_allowin, 1);
    check("bp_release_res",     MEM_to_WB_BUS[32:1], 32'hDEAD_BEEF);
    tick();
    check("bp_done", MEM_to_WB_valid, 0);

    // Spurious data_ok in IDLE, then a ld.w takes its own response
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hFFFF_FFFF;
    #1;
    check("spur_valid", MEM_to_WB_valid, 0);
    tick();
    check("spur_allowin", MEM_allowin, 1);
    check("spur_valid2",  MEM_to_WB_valid, 0);
    data_sram_data_ok = 1'b0;
    EX_to_MEM_valid   = 1'b1;
    EX_to_MEM_BUS     = mk_ex(32'h5000, 1'b1, 5'd11, 32'h0000_0400, 5'b10000, 1'b1);
    tick();
    EX_to_MEM_valid = 1'b0;
    #1;
    check("spur_ldw_wait", MEM_to_WB_valid, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    #1;
    check("spur_ldw_res", MEM_to_WB_BUS[32:1], 32'h0BAD_F00D);
    tick();
    data_sram_data_ok = 1'b0;

    // Reset while waiting; a late response is ignored
    EX_to_MEM_valid = 1'b1;
    EX_to_MEM_BUS   = mk_ex(32'h6000, 1'b1, 5'd12, 32'h0000_0500, 5'b10000, 1'b1);
    tick();
    EX_to_MEM_valid = 1'b0;
    #1;
    check("rw_wait_allowin", MEM_allowin, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rw_valid",   MEM_to_WB_valid, 0);
    check("rw_allowin", MEM_allowin, 1);
    check("rw_bus",     MEM_to_WB_BUS, 0);
    check("rw_rf",      MEM_RF_BUS, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_5555;
    tick();
    data_sram_data_ok = 1'b0;
    #1;
    check("rw_late_valid",   MEM_to_WB_valid, 0);
    check("rw_late_allowin", MEM_allowin, 1);
    check("rw_late_bus",     MEM_to_WB_BUS, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
